mont_exp_ctrl: RTL and testbench
================================

// Module: mont_exp_ctrl
// PURPOSE
//  Sequencer for one shared Montgomery multiplier (start/done, 1024-bit operands, 1025-bit result).
//  Computes left-to-right binary modular exponentiation in the Montgomery domain: A = MM(A,A); if e[i] A = MM(A,X).
//  Sits between the top-level RSA/host interface and the multiplier. Owns all operand muxing and loop control.
// PARAMETERS
//  N     1024  operand/modulus width in bits
//  E     1024  maximum exponent width in bits
//  LW    11    width of exponent-length field, = clog2(E)+1
// PORTS
//  clk        in   1    system clock, rising edge
//  resetn     in   1    asynchronous active-low reset
//  start      in   1    1-cycle pulse; latches operands when idle
//  in_x       in   N    base, already in Montgomery form (X*R mod M)
//  in_r       in   N    Montgomery one (R mod M), initial accumulator
//  in_m       in   N    modulus, odd
//  in_e       in   E    exponent
//  in_elen    in   LW   number of exponent bits to process (0..E), MSB = in_e[in_elen-1]
//  busy       out  1    high from the cycle after start until done
//  done       out  1    1-cycle pulse, result valid from this cycle until next start
//  result     out  N    final accumulator (Montgomery form)
//  mm_start   out  1    1-cycle start pulse to multiplier
//  mm_a       out  N    multiplier operand A (always accumulator)
//  mm_b       out  N    multiplier operand B (accumulator on square, X on multiply)
//  mm_m       out  N    modulus to multiplier (registered copy of in_m)
//  mm_result  in   N+1  multiplier result, fully reduced (< M)
//  mm_done    in   1    multiplier completion pulse
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; busy, done, mm_start = 0; result, mm_a, mm_b, mm_m = 0; all regs cleared.
//  Reset mid-operation aborts immediately; mm_start low in the same cycle; no done issued.
//  States: IDLE -> LOAD -> SQ_GO -> SQ_WAIT -> (MUL_GO -> MUL_WAIT) -> NEXT -> SQ_GO | FIN -> IDLE.
//   IDLE:     start=1 latches x,r,m,e,elen into regs; -> LOAD. start while not IDLE is ignored.
//   LOAD:     acc<=r, bit index i<=elen-1; elen==0 -> FIN (no mm_start ever), else -> SQ_GO.
//   SQ_GO:    mm_b selects acc; mm_start=1 for exactly this cycle; -> SQ_WAIT.
//   SQ_WAIT:  on mm_done, acc<=mm_result[N-1:0]; e[i]=1 -> MUL_GO, else -> NEXT.
//   MUL_GO:   mm_b selects x; mm_start=1 for this cycle; -> MUL_WAIT.
//   MUL_WAIT: on mm_done, acc<=mm_result[N-1:0]; -> NEXT.
//   NEXT:     i==0 -> FIN, else i<=i-1 -> SQ_GO.
//   FIN:      result<=acc, done=1 (1 cycle), busy<=0; -> IDLE.
//  mm_a/mm_b/mm_m are registered and stable from the GO cycle until mm_done is seen.
//  mm_done sampled only in *_WAIT; pulses in any other state are ignored.
//  mm_result[N] is ignored (multiplier guarantees < M); no subtraction here.
//  Multiplications per run = elen + popcount(e[elen-1:0]); latency = 3 + sum(mm latency + 2).
//  Bits of in_e at or above in_elen are don't-care. in_elen > E is clamped to E.
// STRUCTURE
//  Shared header mont_defs.vh: N/E defaults, state encodings, MM_SEL_ACC/MM_SEL_X codes.
//  Sub-module mont_exp_bitscan: exponent shift reg + down counter; outputs cur_bit, last; inputs load, step.
//  Top: FSM, acc/x/m registers, operand mux; multiplier instantiated by the parent, not here.
// TESTING (bench with N=8, E=8, behavioural MM model, variable mm latency 1..20 cycles)
//  M=13, x=5 (2*R mod 13), r=9, e=8'b1011, elen=4 -> result=11, done once, exactly 7 mm_start pulses.
//  elen=0, any e -> result=in_r=9, done 3 cycles after start, zero mm_start pulses.
//  e=8'hFF, elen=8, x=5, r=9, M=13 -> 16 mm_start pulses, result matches golden 2^255*R mod 13.
//  start re-pulsed during SQ_WAIT and spurious mm_done in IDLE/NEXT -> no effect, same result as clean run.
//  resetn low during MUL_WAIT -> busy/mm_start 0 immediately; next start runs clean to correct result.
//  Back-to-back: start in cycle after done -> second run correct, result held stable until its FIN.

Source files
------------

// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types for the Montgomery exponentiation sequencer: FSM states and
// multiplier operand-B select codes.
package mont_exp_ctrl_pkg;

  localparam int unsigned N_DEF  = 1024;
  localparam int unsigned E_DEF  = 1024;
  localparam int unsigned LW_DEF = 11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_SQ_GO    = 4'd2,
    ST_SQ_WAIT  = 4'd3,
    ST_MUL_GO   = 4'd4,
    ST_MUL_WAIT = 4'd5,
    ST_NEXT     = 4'd6,
    ST_FIN      = 4'd7
  } state_e;

  typedef enum logic {
    MM_SEL_ACC = 1'b0,
    MM_SEL_X   = 1'b1
  } mm_sel_e;

  // True for the states that issue a multiplier start pulse.
  function automatic logic is_go(input state_e s);
    return (s == ST_SQ_GO) || (s == ST_MUL_GO);
  endfunction

endpackage

// File: rtl/mont_exp_ctrl_bitscan.sv
// Exponent bit scanner: left-aligns the active exponent bits so the current
// bit is always the MSB, with a down counter flagging the last bit.
module mont_exp_ctrl_bitscan #(
  parameter int unsigned E  = 1024,
  parameter int unsigned LW = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          step,
  input  logic [E-1:0]  e,
  input  logic [LW-1:0] elen,
  output logic          cur_bit,
  output logic          last
);

  logic [E-1:0]  shift_r;
  logic [LW-1:0] cnt_r;
  logic [LW-1:0] shamt_s;

  // elen is already clamped to E, so the shift never goes negative.
  assign shamt_s = LW'(E) - elen;
  assign cur_bit = shift_r[E-1];
  assign last    = (cnt_r == {LW{1'b0}});

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_r <= {E{1'b0}};
      cnt_r   <= {LW{1'b0}};
    end else if (load) begin
      shift_r <= e << shamt_s;
      cnt_r   <= elen - LW'(1);
    end else if (step) begin
      shift_r <= shift_r << 1;
      cnt_r   <= cnt_r - LW'(1);
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving one shared
// Montgomery multiplier; acc = MM(acc,acc) per bit, then MM(acc,x) on set bits.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned E  = E_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [N-1:0]  in_x,
  input  logic [N-1:0]  in_r,
  input  logic [N-1:0]  in_m,
  input  logic [E-1:0]  in_e,
  input  logic [LW-1:0] in_elen,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          mm_start,
  output logic [N-1:0]  mm_a,
  output logic [N-1:0]  mm_b,
  output logic [N-1:0]  mm_m,
  input  logic [N:0]    mm_result,
  input  logic          mm_done
);

  state_e        state_r, state_nxt_s;
  mm_sel_e       sel_s;
  logic [N-1:0]  x_r, r_r, acc_r, acc_nxt_s, mm_b_nxt_s;
  logic [LW-1:0] elen_r, elen_clamp_s;
  logic          busy_r, done_r, mm_start_r;
  logic [N-1:0]  result_r, mm_a_r, mm_b_r, mm_m_r;
  logic          load_s, step_s, go_s, cur_bit_s, last_s;
  logic          unused_mm_msb_s;

  // The multiplier guarantees a reduced result, so its top bit carries nothing.
  assign unused_mm_msb_s = mm_result[N];
  assign elen_clamp_s    = (in_elen > LW'(E)) ? LW'(E) : in_elen;

  mont_exp_ctrl_bitscan #(.E(E), .LW(LW)) u_bitscan (
    .clk     (clk),
    .resetn  (resetn),
    .load    (load_s),
    .step    (step_s),
    .e       (in_e),
    .elen    (elen_clamp_s),
    .cur_bit (cur_bit_s),
    .last    (last_s)
  );

  // Next-state, accumulator update and bit-scan control.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        acc_nxt_s = r_r;
        if (elen_r == {LW{1'b0}}) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_SQ_GO;
        end
      end
      ST_SQ_GO: state_nxt_s = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (mm_done) begin
          acc_nxt_s   = mm_result[N-1:0];
          state_nxt_s = cur_bit_s ? ST_MUL_GO : ST_NEXT;
        end else begin
          state_nxt_s = ST_SQ_WAIT;
        end
      end
      ST_MUL_GO: state_nxt_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mm_done) begin
          acc_nxt_s   = mm_result[N-1:0];
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_MUL_WAIT;
        end
      end
      ST_NEXT: begin
        if (last_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          step_s      = 1'b1;
          state_nxt_s = ST_SQ_GO;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operands are captured on entry to a GO state so they already hold the
  // freshly updated accumulator while mm_start is high.
  always_comb begin
    go_s       = is_go(state_nxt_s);
    sel_s      = (state_nxt_s == ST_MUL_GO) ? MM_SEL_X : MM_SEL_ACC;
    mm_b_nxt_s = acc_nxt_s;
    case (sel_s)
      MM_SEL_X:   mm_b_nxt_s = x_r;
      MM_SEL_ACC: mm_b_nxt_s = acc_nxt_s;
      default:    mm_b_nxt_s = acc_nxt_s;
    endcase
  end

  // State, operand latches and accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      acc_r   <= {N{1'b0}};
      x_r     <= {N{1'b0}};
      r_r     <= {N{1'b0}};
      mm_m_r  <= {N{1'b0}};
      elen_r  <= {LW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      if (load_s) begin
        x_r    <= in_x;
        r_r    <= in_r;
        mm_m_r <= in_m;
        elen_r <= elen_clamp_s;
      end
    end
  end

  // Registered host and multiplier outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= {N{1'b0}};
      mm_start_r <= 1'b0;
      mm_a_r     <= {N{1'b0}};
      mm_b_r     <= {N{1'b0}};
    end else begin
      if (load_s) begin
        busy_r <= 1'b1;
      end else if (state_r == ST_FIN) begin
        busy_r <= 1'b0;
      end
      done_r     <= (state_r == ST_FIN);
      mm_start_r <= go_s;
      if (state_r == ST_FIN) begin
        result_r <= acc_r;
      end
      if (go_s) begin
        mm_a_r <= acc_nxt_s;
        mm_b_r <= mm_b_nxt_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign mm_start = mm_start_r;
  assign mm_a     = mm_a_r;
  assign mm_b     = mm_b_r;
  assign mm_m     = mm_m_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl at N=E=8 with a behavioural Montgomery multiplier of
// random latency and an arithmetic reference for x^e in Montgomery form.
module tb_mont_exp_ctrl;

  localparam int N  = 8;
  localparam int E  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn, start;
  logic [N-1:0]  in_x, in_r, in_m;
  logic [E-1:0]  in_e;
  logic [LW-1:0] in_elen;
  logic          busy, done, mm_start, mm_done;
  logic [N-1:0]  result, mm_a, mm_b, mm_m;
  logic [N:0]    mm_result;
  bit            spur_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.N(N), .E(E), .LW(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
    .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  function automatic int rinv(input int m);
    for (int t = 1; t < m; t++) if (((256 * t) % m) == 1) return t;
    return 0;
  endfunction

  function automatic int mm_model(input int a, input int b, input int m);
    return ((a * b) % m) * rinv(m) % m;
  endfunction

  // Montgomery form of (x/R)^e: plain repeated multiplication, times R.
  function automatic int exp_model(input int x, input int e, input int m);
    int base, p;
    base = (x * rinv(m)) % m;
    p = 1 % m;
    for (int k = 0; k < e; k++) p = (p * base) % m;
    return (p * 256) % m;
  endfunction

  function automatic int popcount(input int v);
    int c = 0;
    for (int k = 0; k < 32; k++) c += (v >> k) & 1;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiplier model: answers each mm_start after 1..20 cycles; optionally
  // injects stray mm_done pulses whenever no real operation is pending.
  initial begin
    int lat, res;
    bit pend;
    pend = 1'b0; lat = 0; res = 0;
    mm_done = 1'b0; mm_result = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (!resetn) begin
        pend = 1'b0;
      end else if (pend) begin
        if (lat <= 1) begin
          mm_done = 1'b1;
          mm_result = {1'($urandom_range(0, 1)), 8'(res)};
          pend = 1'b0;
        end else begin
          lat--;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        mm_done = 1'b1;
        mm_result = 9'($urandom);
      end
      if (resetn && mm_start) begin
        pend = 1'b1;
        lat = int'($urandom_range(1, 20));
        res = mm_model(int'(mm_a), int'(mm_b), int'(mm_m));
      end
    end
  end

  task automatic run(input string tag, input int m, input int x, input int r, input int e,
                     input int elen, input int exp_res, input int exp_pulses,
                     input int exp_lat, input bit repulse);
    int cyc, pulses;
    bit seen, hold_ok, busy1;
    logic [N-1:0] prev;
    prev = result; hold_ok = 1'b1; busy1 = 1'b0;
    in_m = 8'(m); in_x = 8'(x); in_r = 8'(r); in_e = 8'(e); in_elen = 4'(elen);
    start = 1'b1;
    cyc = 0; pulses = 0; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (repulse && cyc == 3) begin
        start = 1'b1;
        in_x = ~in_x; in_r = ~in_r; in_e = ~in_e; in_m = in_m ^ 8'h02; in_elen = 4'd8;
      end
      if (cyc == 1) busy1 = busy;
      if (mm_start) pulses++;
      if (done) seen = 1'b1;
      else if (result !== prev) hold_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_mm_starts"}, 32'(pulses), 32'(exp_pulses));
    chk({tag, "_result_held"}, 32'(hold_ok), 32'd1);
    chk({tag, "_busy_after_start"}, 32'(busy1), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_mm_m"}, 32'(mm_m), 32'(m));
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  task automatic quiet(input string tag, input int n);
    bit extra = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done) extra = 1'b1;
    end
    chk({tag, "_no_second_done"}, 32'(extra), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int m, x, e, elen, elen_c, e_eff, cyc, pulses;
    resetn = 1'b0; start = 1'b0;
    in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_elen = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mm_start", 32'(mm_start), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mm_a", 32'(mm_a), 32'd0);
    chk("rst_mm_b", 32'(mm_b), 32'd0);
    chk("rst_mm_m", 32'(mm_m), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    run("spec_1011", 13, 5, 9, 8'b1011, 4, 11, 7, 0, 1'b0);
    quiet("spec_1011", 5);
    run("elen0", 13, 5, 9, 8'hA5, 0, 9, 0, 3, 1'b0);
    quiet("elen0", 3);
    run("e_ff", 13, 5, 9, 8'hFF, 8, 7, 16, 0, 1'b0);
    quiet("e_ff", 3);
    run("elen_clamp", 13, 5, 9, 8'hFF, 12, 7, 16, 0, 1'b0);
    quiet("elen_clamp", 3);

    spur_en = 1'b1;
    quiet("spur_idle", 10);
    run("repulse", 13, 5, 9, 8'b1011, 4, 11, 7, 0, 1'b1);
    quiet("repulse", 5);

    // Abort in MUL_WAIT: the second multiplier start of e=1011 is the first multiply.
    in_m = 8'd13; in_x = 8'd5; in_r = 8'd9; in_e = 8'b1011; in_elen = 4'd4;
    start = 1'b1; cyc = 0; pulses = 0;
    while (pulses < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mm_start) pulses++;
    end
    chk("abort_reached_mul", 32'(pulses), 32'd2);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mm_start", 32'(mm_start), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mm_a", 32'(mm_a), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run("after_abort", 13, 5, 9, 8'b1011, 4, 11, 7, 0, 1'b0);

    @(negedge clk);
    run("b2b_first", 13, 5, 9, 8'hFF, 8, 7, 16, 0, 1'b0);
    @(negedge clk);
    run("b2b_second", 13, 5, 9, 8'b1011, 4, 11, 7, 0, 1'b0);
    quiet("b2b", 3);

    for (int k = 0; k < 12; k++) begin
      m = 2 * int'($urandom_range(1, 127)) + 1;
      x = int'($urandom_range(0, m - 1));
      e = int'($urandom_range(0, 255));
      elen = int'($urandom_range(0, 10));
      elen_c = (elen > 8) ? 8 : elen;
      e_eff = e & ((1 << elen_c) - 1);
      run($sformatf("rand%0d", k), m, x, 256 % m, e, elen,
          exp_model(x, e_eff, m), elen_c + popcount(e_eff),
          (elen_c == 0) ? 3 : 0, 1'b0);
      quiet($sformatf("rand%0d", k), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
